crossbar_scheduler: RTL and testbench

- Per-output round-robin arbiter and connection controller for the N×N crossbar_switch datapath.
- Takes packet requests from N input ports (valid/dest/last), grants each output to one input at a time, and holds the connection until the packet's last beat.
- Drives the crossbar's packed select bus and gates the valid/ready handshakes between sources and sinks.

---
 rtl/crossbar_scheduler.sv | 113 +++++++++++
 tb/tb_crossbar_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_scheduler.sv
// crossbar_scheduler: per-output round-robin arbiter and connection
// controller that drives the crossbar select bus and gates handshakes.
module crossbar_scheduler #(
  parameter  int N  = 3,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  input  logic [N*SW-1:0] in_dest,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  input  logic [N-1:0]    out_ready,
  output logic [N-1:0]    out_valid,
  output logic [N*SW-1:0] select,
  output logic [N-1:0]    busy,
  output logic            err_dest
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t        state_q [N];
  logic [SW-1:0] owner_q [N];
  logic [SW-1:0] rr_q    [N];

  logic [N-1:0]  gnt_vld;
  logic [SW-1:0] gnt_idx [N];
  logic [N-1:0]  hs_end;
  logic          dest_bad;

  // Scan from rr pointer; first matching requester wins.
  always_comb begin
    int idx;
    idx = 0;
    for (int j = 0; j < N; j++) begin
      gnt_vld[j] = 1'b0;
      gnt_idx[j] = '0;
      for (int k = 0; k < N; k++) begin
        idx = int'(rr_q[j]) + k;
        if (idx >= N) idx = idx - N;
        if (!gnt_vld[j] && in_valid[idx] &&
            int'(in_dest[idx*SW +: SW]) == j) begin
          gnt_vld[j] = 1'b1;
          gnt_idx[j] = SW'(idx);
        end
      end
    end
  end

  always_comb begin
    dest_bad = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && int'(in_dest[i*SW +: SW]) >= N)
        dest_bad = 1'b1;
    end
  end

  always_comb begin
    in_ready  = '0;
    out_valid = '0;
    busy      = '0;
    hs_end    = '0;
    if (!rst) begin
      for (int j = 0; j < N; j++) begin
        if (state_q[j] == LOCKED) begin
          busy[j]               = 1'b1;
          out_valid[j]          = in_valid[owner_q[j]];
          in_ready[owner_q[j]]  = out_ready[j];
          hs_end[j]             = in_valid[owner_q[j]] &
                                  out_ready[j] &
                                  in_last[owner_q[j]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N; j++) begin
        state_q[j] <= IDLE;
        owner_q[j] <= '0;
        rr_q[j]    <= '0;
      end
      select   <= '0;
      err_dest <= 1'b0;
    end else begin
      for (int j = 0; j < N; j++) begin
        unique case (state_q[j])
          IDLE: begin
            if (gnt_vld[j]) begin
              state_q[j]           <= LOCKED;
              owner_q[j]           <= gnt_idx[j];
              select[j*SW +: SW]   <= gnt_idx[j];
            end
          end
          LOCKED: begin
            if (hs_end[j]) begin
              state_q[j] <= IDLE;
              rr_q[j]    <= (int'(owner_q[j]) == N - 1) ?
                            '0 : owner_q[j] + 1'b1;
            end
          end
          default: state_q[j] <= IDLE;
        endcase
      end
      if (dest_bad) err_dest <= 1'b1;
    end
  end

endmodule

// File: tb/tb_crossbar_scheduler.sv
// tb_crossbar_scheduler: directed and random stimulus checked against
// a packet-level reference model of the scheduler.
module tb_crossbar_scheduler;

  localparam int N  = 3;
  localparam int SW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N*SW-1:0] in_dest;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    out_ready;
  logic [N-1:0]    out_valid;
  logic [N*SW-1:0] select;
  logic [N-1:0]    busy;
  logic            err_dest;

  crossbar_scheduler #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_dest   (in_dest),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .select    (select),
    .busy      (busy),
    .err_dest  (err_dest)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  bit m_lock [N];
  int m_own  [N];
  int m_rr   [N];
  int m_sel  [N];
  bit m_err;

  int           g_left [N];
  int           g_dest [N];
  bit           g_rv;
  bit           g_ro;
  logic [N-1:0] g_ordy;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic int dest_of(input int i);
    return int'(in_dest[i*SW +: SW]);
  endfunction

  task automatic gen_new();
    for (int i = 0; i < N; i++) begin
      if (g_left[i] == 0 && $urandom_range(2) == 0) begin
        g_left[i] = int'($urandom_range(4, 1));
        g_dest[i] = int'($urandom_range(N - 1));
      end
    end
  endtask

  task automatic gen_drive();
    for (int i = 0; i < N; i++) begin
      if (g_left[i] > 0) begin
        in_valid[i] = g_rv ? ($urandom_range(3) != 0) : 1'b1;
        in_dest[i*SW +: SW] = SW'(g_dest[i]);
      end else begin
        in_valid[i] = 1'b0;
        in_dest[i*SW +: SW] = SW'($urandom);
      end
      in_last[i] = (g_left[i] == 1);
    end
    for (int j = 0; j < N; j++)
      out_ready[j] = g_ro ? ($urandom_range(3) != 0) : g_ordy[j];
  endtask

  // One clock: check outputs against the model, then advance it.
  task automatic step();
    logic [N-1:0]    ir, ov, bz, hs;
    logic [N*SW-1:0] es;
    int best, bd, d;
    @(negedge clk);
    ir = '0; ov = '0; bz = '0; es = '0;
    for (int j = 0; j < N; j++) begin
      es[j*SW +: SW] = SW'(m_sel[j]);
      if (!rst && m_lock[j]) begin
        bz[j] = 1'b1;
        ov[j] = in_valid[m_own[j]];
        ir[m_own[j]] = out_ready[j];
      end
    end
    chk("in_ready",  32'(in_ready),  32'(ir));
    chk("out_valid", 32'(out_valid), 32'(ov));
    chk("busy",      32'(busy),      32'(bz));
    chk("select",    32'(select),    32'(es));
    chk("err_dest",  32'(err_dest),  32'(m_err));
    hs = in_valid & ir;
    @(posedge clk);
    if (rst) begin
      for (int j = 0; j < N; j++) begin
        m_lock[j] = 0; m_own[j] = 0; m_rr[j] = 0; m_sel[j] = 0;
      end
      m_err = 0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (m_lock[j]) begin
          if (hs[m_own[j]] && in_last[m_own[j]]) begin
            m_lock[j] = 0;
            m_rr[j] = (m_own[j] + 1) % N;
          end
        end else begin
          best = -1; bd = N;
          for (int i = 0; i < N; i++) begin
            if (in_valid[i] && dest_of(i) == j) begin
              d = (i - m_rr[j] + N) % N;
              if (d < bd) begin bd = d; best = i; end
            end
          end
          if (best >= 0) begin
            m_lock[j] = 1; m_own[j] = best; m_sel[j] = best;
          end
        end
      end
      for (int i = 0; i < N; i++)
        if (in_valid[i] && dest_of(i) >= N) m_err = 1;
    end
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i] && g_left[i] > 0) g_left[i]--;
  endtask

  task automatic drain();
    int pend;
    g_rv = 0; g_ro = 0; g_ordy = '1;
    for (int c = 0; c < 40; c++) begin
      pend = 0;
      for (int i = 0; i < N; i++) if (g_left[i] > 0) pend++;
      if (pend == 0) break;
      gen_drive();
      step();
    end
    pend = 0;
    for (int i = 0; i < N; i++) if (g_left[i] > 0) pend++;
    chk("drain_pending", 32'(pend), 32'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_err = 0;
    for (int i = 0; i < N; i++) begin
      g_left[i] = 0; g_dest[i] = 0;
      m_lock[i] = 0; m_own[i] = 0; m_rr[i] = 0; m_sel[i] = 0;
    end
    g_rv = 1; g_ro = 1; g_ordy = '1;
    rst = 1'b1;
    gen_new();
    gen_drive();
    @(posedge clk);
    #1;
    repeat (2) begin
      gen_new();
      gen_drive();
      step();
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_sel", 32'(select), 32'(0));
    end
    for (int i = 0; i < N; i++) g_left[i] = 0;
    rst = 1'b0;
    g_rv = 0; g_ro = 0;

    g_left[1] = 1; g_dest[1] = 2;
    gen_drive();
    step();
    chk("sg_sel2", 32'(select[2*SW +: SW]), 32'(1));
    chk("sg_busy", 32'(busy), 32'(3'b100));
    chk("sg_oval", 32'(out_valid), 32'(3'b100));
    chk("sg_irdy", 32'(in_ready), 32'(3'b010));
    gen_drive();
    step();
    gen_drive();
    chk("sg_done", 32'(busy), 32'(0));
    step();

    for (int i = 0; i < N; i++) begin
      g_left[i] = 2; g_dest[i] = 0;
    end
    gen_drive();
    step();
    for (int c = 0; c < 9; c++) begin
      chk("rr_busy", 32'(busy[0]), 32'(c % 3 != 2));
      if (c % 3 != 2)
        chk("rr_owner", 32'(select[0 +: SW]), 32'(c / 3));
      gen_drive();
      step();
    end
    g_left[0] = 1; g_dest[0] = 0;
    g_left[1] = 1; g_dest[1] = 0;
    gen_drive();
    step();
    chk("rr_wrap", 32'(select[0 +: SW]), 32'(0));
    drain();

    g_left[0] = 4; g_dest[0] = 1;
    gen_drive();
    step();
    gen_drive();
    step();
    g_ordy = 3'b101;
    for (int k = 0; k < 3; k++) begin
      gen_drive();
      #1;
      chk("bp_irdy", 32'(in_ready[0]), 32'(0));
      chk("bp_busy", 32'(busy[1]), 32'(1));
      chk("bp_sel", 32'(select[SW +: SW]), 32'(0));
      step();
    end
    g_ordy = '1;
    gen_drive();
    #1;
    chk("bp_resume", 32'(in_ready[0]), 32'(1));
    step();
    drain();

    g_left[0] = 2; g_dest[0] = 1;
    g_left[1] = 2; g_dest[1] = 2;
    g_left[2] = 2; g_dest[2] = 0;
    gen_drive();
    step();
    chk("perm_busy", 32'(busy), 32'(3'b111));
    chk("perm_sel", 32'(select), 32'(6'b01_00_10));
    chk("perm_oval", 32'(out_valid), 32'(3'b111));
    drain();

    g_left[0] = 5; g_dest[0] = 3;
    gen_drive();
    step();
    chk("bad_err", 32'(err_dest), 32'(1));
    for (int k = 0; k < 3; k++) begin
      chk("bad_busy", 32'(busy), 32'(0));
      chk("bad_irdy", 32'(in_ready), 32'(0));
      gen_drive();
      step();
    end
    g_left[0] = 0;

    g_left[1] = 4; g_dest[1] = 0;
    gen_drive();
    step();
    gen_drive();
    step();
    chk("mr_locked", 32'(busy[0]), 32'(1));
    rst = 1'b1;
    gen_drive();
    #1;
    chk("mr_force", 32'(busy | in_ready | out_valid), 32'(0));
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) g_left[i] = 0;
    gen_drive();
    #1;
    chk("mr_busy", 32'(busy), 32'(0));
    chk("mr_err", 32'(err_dest), 32'(0));
    step();

    g_rv = 1; g_ro = 1;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(199) == 0);
      gen_new();
      gen_drive();
      step();
      if (rst)
        for (int i = 0; i < N; i++) g_left[i] = 0;
    end
    rst = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
